// File: rtl/calc3_sched_pkg.sv
// calc3_sched_pkg: shared widths, command codes, request bundle and hazard
// decoding for the CALC3 issue scheduler.
package calc3_sched_pkg;

    localparam int NPORTS = 4;
    localparam int PORT_W = 2;   // NPORTS must equal 2**PORT_W for the rr wrap
    localparam int NREGS  = 16;
    localparam int REG_W  = 4;
    localparam int CMD_W  = 4;
    localparam int TAG_W  = 2;
    localparam int DATA_W = 32;

    typedef enum logic [CMD_W-1:0] {
        NOP   = 4'd0,
        ADD   = 4'd1,
        SUB   = 4'd2,
        SHL   = 4'd5,
        SHR   = 4'd6,
        STORE = 4'd9,
        FETCH = 4'd10,
        BZ    = 4'd12,
        BEQ   = 4'd13
    } cmd_e;

    // cmd stays a raw code: undefined codes are queued and issued untouched,
    // and the ALU answers them with its invalid response.
    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [REG_W-1:0]  d1;
        logic [REG_W-1:0]  d2;
        logic [REG_W-1:0]  r1;
    } req_s;

    // Commands that update r1 once the ALU finishes.
    function automatic logic is_writer(input logic [CMD_W-1:0] cmd);
        return cmd inside {ADD, SUB, SHL, SHR, STORE};
    endfunction

    // Commands that read source register d1.
    function automatic logic reads_d1(input logic [CMD_W-1:0] cmd);
        return cmd inside {ADD, SUB, SHL, SHR, BZ, BEQ, FETCH};
    endfunction

    // Commands that read source register d2.
    function automatic logic reads_d2(input logic [CMD_W-1:0] cmd);
        return cmd inside {ADD, SUB, SHL, SHR, BZ, BEQ};
    endfunction

    // Every register a command must find idle before it may issue:
    // its sources (RAW) and, for writers, its destination (WAW).
    function automatic logic [NREGS-1:0] hazard_mask(input req_s req);
        logic [NREGS-1:0] mask;
        mask = '0;
        if (reads_d1(req.cmd))  mask[req.d1] = 1'b1;
        if (reads_d2(req.cmd))  mask[req.d2] = 1'b1;
        if (is_writer(req.cmd)) mask[req.r1] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/calc3_port_fifo.sv
// calc3_port_fifo: one requester queue of req_s entries with a combinational
// head. A push into a full queue is accepted when the same cycle pops.
module calc3_port_fifo
    import calc3_sched_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic c_clk,
    input  logic reset,
    input  logic push,
    input  req_s push_req,
    input  logic pop,
    output req_s head,
    output logic full,
    output logic empty
);

    localparam int              AW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [AW-1:0]   LAST  = AW'(QDEPTH - 1);
    localparam logic [AW:0]     DEPTH = (AW+1)'(QDEPTH);

    req_s          mem [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;      // one extra bit so full and empty are distinct
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap at QDEPTH explicitly.
    always_ff @(posedge c_clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of block evaluation order.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge c_clk) begin
        // NOTE: the payload array has no reset; occupancy is carried by count,
        // so stale entries are never observed and the RAM stays reset-free.
        if (do_push) mem[wr_ptr] <= push_req;
    end

endmodule

// File: rtl/calc3_issue_scheduler.sv
// calc3_issue_scheduler: four per-port command queues, a round-robin arbiter
// gated by a 16-entry register scoreboard, and the registered issue bundle
// that feeds the ALU issue stage.
module calc3_issue_scheduler
    import calc3_sched_pkg::*;
#(
    parameter int QDEPTH  = 4,
    parameter int ALU_LAT = 3
) (
    input  logic                          c_clk,
    input  logic                          reset,
    input  logic [NPORTS-1:0][CMD_W-1:0]  reqcmd,
    input  logic [NPORTS-1:0][TAG_W-1:0]  reqtag,
    input  logic [NPORTS-1:0][DATA_W-1:0] req_data,
    input  logic [NPORTS-1:0][REG_W-1:0]  req_d1,
    input  logic [NPORTS-1:0][REG_W-1:0]  req_d2,
    input  logic [NPORTS-1:0][REG_W-1:0]  req_r1,
    output logic                          iss_valid,
    output logic [PORT_W-1:0]             iss_port,
    output logic [CMD_W-1:0]              iss_cmd,
    output logic [TAG_W-1:0]              iss_tag,
    output logic [REG_W-1:0]              iss_d1,
    output logic [REG_W-1:0]              iss_d2,
    output logic [REG_W-1:0]              iss_r1,
    output logic [DATA_W-1:0]             iss_data,
    output logic [NREGS-1:0]              reg_busy,
    output logic [NPORTS-1:0]             ovf_err
);

    req_s [NPORTS-1:0]  push_req;
    req_s [NPORTS-1:0]  head;
    logic [NPORTS-1:0]  push;
    logic [NPORTS-1:0]  pop;
    logic [NPORTS-1:0]  full;
    logic [NPORTS-1:0]  empty;
    logic [NPORTS-1:0]  eligible;

    logic [PORT_W-1:0]  rr_q;
    logic [PORT_W-1:0]  cand;
    logic [PORT_W-1:0]  grant_idx;
    logic               grant_vld;
    req_s               sel_req;

    // Scoreboard release pipeline: one slot per cycle of ALU latency.
    logic [ALU_LAT-1:0]            pipe_vld;
    logic [ALU_LAT-1:0][REG_W-1:0] pipe_r1;
    logic                          set_vld;
    logic [NREGS-1:0]              set_mask;
    logic [NREGS-1:0]              clr_mask;
    logic [NREGS-1:0]              busy_view;

    // Per-port queues and their head eligibility.
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        assign push[p]     = (reqcmd[p] != '0);
        assign push_req[p] = '{cmd:  reqcmd[p],
                               tag:  reqtag[p],
                               data: req_data[p],
                               d1:   req_d1[p],
                               d2:   req_d2[p],
                               r1:   req_r1[p]};

        calc3_port_fifo #(
            .QDEPTH (QDEPTH)
        ) u_fifo (
            .c_clk    (c_clk),
            .reset    (reset),
            .push     (push[p]),
            .push_req (push_req[p]),
            .pop      (pop[p]),
            .head     (head[p]),
            .full     (full[p]),
            .empty    (empty[p])
        );

        assign eligible[p] = !empty[p] && ((hazard_mask(head[p]) & busy_view) == '0);
    end

    // A register whose release is due this edge already counts as free, so a
    // dependent command issues exactly ALU_LAT cycles after its producer.
    assign busy_view = reg_busy & ~clr_mask;

    // Round-robin search from rr_q; ineligible ports are skipped, not waited on.
    always_comb begin
        // NOTE: defaults come first so no path leaves an output unassigned,
        // which would otherwise infer a latch.
        grant_vld = 1'b0;
        grant_idx = rr_q;
        cand      = rr_q;
        for (int k = 0; k < NPORTS; k++) begin
            cand = rr_q + PORT_W'(k);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign sel_req = head[grant_idx];
    assign set_vld = grant_vld && is_writer(sel_req.cmd);

    // Dequeue strobe for the granted port only.
    always_comb begin
        pop = '0;
        if (grant_vld) pop[grant_idx] = 1'b1;
    end

    // Scoreboard set (new writer) and clear (oldest in-flight writer) masks.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_vld)                set_mask[sel_req.r1]          = 1'b1;
        if (pipe_vld[ALU_LAT-1])    clr_mask[pipe_r1[ALU_LAT-1]]  = 1'b1;
    end

    // Arbitration pointer: moves past the winner, holds when nothing issues.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            rr_q <= '0;
        end else if (grant_vld) begin
            rr_q <= grant_idx + PORT_W'(1);
        end
    end

    // Issue bundle: strobe every cycle, fields only on a grant so they hold.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            iss_valid <= 1'b0;
            iss_port  <= '0;
            iss_cmd   <= '0;
            iss_tag   <= '0;
            iss_d1    <= '0;
            iss_d2    <= '0;
            iss_r1    <= '0;
            iss_data  <= '0;
        end else begin
            iss_valid <= grant_vld;
            if (grant_vld) begin
                iss_port <= grant_idx;
                iss_cmd  <= sel_req.cmd;
                iss_tag  <= sel_req.tag;
                iss_d1   <= sel_req.d1;
                iss_d2   <= sel_req.d2;
                iss_r1   <= sel_req.r1;
                iss_data <= sel_req.data;
            end
        end
    end

    // In-flight writer countdown: the r1 leaving the last stage is released.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            pipe_r1  <= '0;
        end else begin
            pipe_vld[0] <= set_vld;
            pipe_r1[0]  <= sel_req.r1;
            for (int k = 1; k < ALU_LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_r1[k]  <= pipe_r1[k-1];
            end
        end
    end

    // Scoreboard: set beats clear when both hit the same register.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            reg_busy <= '0;
        end else begin
            reg_busy <= (reg_busy & ~clr_mask) | set_mask;
        end
    end

    // Sticky overflow: a command arrived at a full queue that did not drain.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            ovf_err <= '0;
        end else begin
            ovf_err <= ovf_err | (push & full & ~pop);
        end
    end

endmodule

// File: tb/tb_calc3_issue_scheduler.sv
// tb_calc3_issue_scheduler: directed scenarios plus randomized traffic, all
// compared every cycle against a queue-based reference model.
module tb_calc3_issue_scheduler;

    localparam int NP      = 4;
    localparam int QD      = 4;
    localparam int LAT     = 3;
    localparam logic [3:0] C_ADD = 4'd1, C_SUB = 4'd2, C_SHL = 4'd5,
                           C_STORE = 4'd9, C_BEQ = 4'd13;

    logic             c_clk;
    logic             reset;
    logic [3:0][3:0]  reqcmd, req_d1, req_d2, req_r1;
    logic [3:0][1:0]  reqtag;
    logic [3:0][31:0] req_data;
    logic             iss_valid;
    logic [1:0]       iss_port;
    logic [3:0]       iss_cmd;
    logic [1:0]       iss_tag;
    logic [3:0]       iss_d1, iss_d2, iss_r1;
    logic [31:0]      iss_data;
    logic [15:0]      reg_busy;
    logic [3:0]       ovf_err;

    calc3_issue_scheduler #(.QDEPTH(QD), .ALU_LAT(LAT)) dut (
        .c_clk(c_clk), .reset(reset),
        .reqcmd(reqcmd), .reqtag(reqtag), .req_data(req_data),
        .req_d1(req_d1), .req_d2(req_d2), .req_r1(req_r1),
        .iss_valid(iss_valid), .iss_port(iss_port), .iss_cmd(iss_cmd),
        .iss_tag(iss_tag), .iss_d1(iss_d1), .iss_d2(iss_d2), .iss_r1(iss_r1),
        .iss_data(iss_data), .reg_busy(reg_busy), .ovf_err(ovf_err)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0] port; logic [3:0] cmd; logic [1:0] tag;
        logic [3:0] d1; logic [3:0] d2; logic [3:0] r1; logic [31:0] data;
    } iss_t;

    iss_t        mq [NP][$];
    int          busy_until [16];   // first edge at which the register is free
    int          m_cyc;
    int          m_rr;
    logic        exp_valid;
    iss_t        exp_iss;
    logic [15:0] exp_busy;
    logic [3:0]  exp_ovf;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_free(input logic [3:0] r);
        return busy_until[r] <= m_cyc;
    endfunction

    function automatic bit m_ready(input iss_t e);
        bit ok;
        ok = 1'b1;
        if (e.cmd inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd10, 4'd12, 4'd13} && !m_free(e.d1)) ok = 1'b0;
        if (e.cmd inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd12, 4'd13} && !m_free(e.d2)) ok = 1'b0;
        if (e.cmd inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd9} && !m_free(e.r1)) ok = 1'b0;
        return ok;
    endfunction

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) mq[p].delete();
        for (int r = 0; r < 16; r++) busy_until[r] = 0;
        m_cyc = 0; m_rr = 0;
        exp_valid = 1'b0; exp_iss = '0; exp_busy = '0; exp_ovf = '0;
    endfunction

    function automatic void model_edge();
        int   g;
        int   p;
        iss_t e;
        g = -1;
        for (int k = 0; k < NP; k++) begin
            p = (m_rr + k) % NP;
            if (g < 0 && mq[p].size() > 0 && m_ready(mq[p][0])) g = p;
        end
        exp_valid = 1'b0;
        if (g >= 0) begin
            e = mq[g].pop_front();
            exp_valid = 1'b1;
            exp_iss = e;
            m_rr = (g + 1) % NP;
            if (e.cmd inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd9}) busy_until[e.r1] = m_cyc + LAT;
        end
        for (int q = 0; q < NP; q++) begin
            if (reqcmd[q] != 4'd0) begin
                e = '{port: 2'(q), cmd: reqcmd[q], tag: reqtag[q], d1: req_d1[q],
                      d2: req_d2[q], r1: req_r1[q], data: req_data[q]};
                if (mq[q].size() < QD) mq[q].push_back(e);
                else exp_ovf[q] = 1'b1;
            end
        end
        for (int r = 0; r < 16; r++) exp_busy[r] = (busy_until[r] > m_cyc);
        m_cyc++;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        reqcmd = '0; reqtag = '0; req_data = '0; req_d1 = '0; req_d2 = '0; req_r1 = '0;
    endtask

    task automatic drive(input int p, input logic [3:0] cmd, input logic [3:0] d1,
                         input logic [3:0] d2, input logic [3:0] r1);
        reqcmd[p] = cmd; req_d1[p] = d1; req_d2[p] = d2; req_r1[p] = r1;
        reqtag[p] = 2'($urandom_range(3)); req_data[p] = $urandom;
    endtask

    task automatic compare_all();
        check("iss_valid", 64'(iss_valid), 64'(exp_valid));
        check("iss_bundle", 64'({iss_port, iss_cmd, iss_tag, iss_d1, iss_d2, iss_r1, iss_data}), 64'(exp_iss));
        check("reg_busy", 64'(reg_busy), 64'(exp_busy));
        check("ovf_err", 64'(ovf_err), 64'(exp_ovf));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(iss_valid), 64'd0);
        check({tag, "_bundle"}, 64'({iss_port, iss_cmd, iss_tag, iss_d1, iss_d2, iss_r1, iss_data}), 64'd0);
        check({tag, "_busy"}, 64'(reg_busy), 64'd0);
        check({tag, "_ovf"}, 64'(ovf_err), 64'd0);
    endtask

    // One clock edge: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge c_clk);
        if (reset) model_reset();
        else       model_edge();
        @(negedge c_clk);
        compare_all();
        clear_inputs();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    logic [3:0] code_tbl [12] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd9,
                                  4'd10, 4'd12, 4'd13, 4'd3, 4'd15, 4'd0};

    int d_issues;

    initial begin
        reset = 1'b1;
        clear_inputs();
        model_reset();

        // Reset state
        apply_reset();
        check_all_zero("reset_state");

        // Single issue and scoreboard window
        drive(0, C_ADD, 4'd1, 4'd2, 4'd3);
        cycle();
        cycle();
        check("single_valid", 64'(iss_valid), 64'd1);
        check("single_port", 64'(iss_port), 64'd0);
        check("single_cmd", 64'(iss_cmd), 64'd1);
        check("single_r1", 64'(iss_r1), 64'd3);
        check("single_busy_e1", 64'(reg_busy[3]), 64'd1);
        cycle();
        check("single_hold_valid", 64'(iss_valid), 64'd0);
        check("single_busy_e2", 64'(reg_busy[3]), 64'd1);
        cycle();
        check("single_busy_e3", 64'(reg_busy[3]), 64'd1);
        cycle();
        check("single_busy_e4", 64'(reg_busy[3]), 64'd0);

        // Round-robin over two bursts
        apply_reset();
        for (int p = 0; p < NP; p++) drive(p, C_ADD, 4'(p), 4'(p), 4'(8 + p));
        cycle();
        for (int k = 0; k < NP; k++) begin
            cycle();
            check("rr_burst1_port", 64'(iss_port), 64'(k));
        end
        for (int p = 0; p < NP; p++) drive(p, C_ADD, 4'(p), 4'(p), 4'(12 + p));
        cycle();
        for (int k = 0; k < NP; k++) begin
            cycle();
            check("rr_burst2_port", 64'(iss_port), 64'(k));
        end

        // RAW hazard with an unrelated command filling the gap
        apply_reset();
        drive(0, C_ADD, 4'd1, 4'd2, 4'd5);
        cycle();
        drive(1, C_SUB, 4'd5, 4'd6, 4'd7);
        drive(2, C_ADD, 4'd10, 4'd11, 4'd12);
        cycle();
        check("raw_e1_port", 64'({iss_valid, iss_port}), 64'({1'b1, 2'd0}));
        cycle();
        check("raw_e2_port", 64'({iss_valid, iss_port}), 64'({1'b1, 2'd2}));
        cycle();
        check("raw_e3_idle", 64'(iss_valid), 64'd0);
        cycle();
        check("raw_e4_sub", 64'({iss_valid, iss_port, iss_cmd}), 64'({1'b1, 2'd1, C_SUB}));

        // WAW hazard, in-order on one port
        apply_reset();
        drive(0, C_STORE, 4'd0, 4'd0, 4'd7);
        cycle();
        drive(0, C_SHL, 4'd1, 4'd2, 4'd7);
        cycle();
        check("waw_e1_store", 64'({iss_valid, iss_cmd}), 64'({1'b1, C_STORE}));
        cycle();
        check("waw_e2_idle", 64'(iss_valid), 64'd0);
        cycle();
        check("waw_e3_idle", 64'(iss_valid), 64'd0);
        cycle();
        check("waw_e4_shl", 64'({iss_valid, iss_cmd}), 64'({1'b1, C_SHL}));

        // Overflow on port d while its head waits on two staggered writer chains
        apply_reset();
        drive(0, C_STORE, 4'd0, 4'd0, 4'd8);
        cycle();
        for (int k = 1; k <= 5; k++) begin
            if (k <= 2) begin
                drive(0, C_STORE, 4'd0, 4'd0, 4'd8);
                drive(1, C_STORE, 4'd0, 4'd0, 4'd9);
            end
            drive(3, C_BEQ, 4'd8, 4'd9, 4'd0);
            cycle();
            if (iss_valid && iss_port == 2'd3) check("ovf_early_issue", 64'd1, 64'd0);
        end
        check("ovf_flag", 64'(ovf_err), 64'h8);
        d_issues = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (iss_valid && iss_port == 2'd3) d_issues++;
        end
        check("ovf_d_issue_count", 64'(d_issues), 64'd4);
        check("ovf_sticky", 64'(ovf_err), 64'h8);

        // Reset asserted mid-flight
        apply_reset();
        drive(0, C_STORE, 4'd0, 4'd0, 4'd4);
        cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1, C_BEQ, 4'd4, 4'd4, 4'd0);
            cycle();
        end
        check("pre_reset_busy", 64'(reg_busy), 64'h0010);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        model_reset();
        cycle();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("post_reset_idle", 64'(iss_valid), 64'd0);
        end

        // Randomized traffic in phases of load and register locality
        for (int ph = 0; ph < 6; ph++) begin
            int pct;
            int rmax;
            pct  = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 60 : 95);
            rmax = (ph < 3) ? 3 : 15;
            if (ph == 3) begin
                #2 reset = 1'b1;
                #1 check_all_zero("rand_async_reset");
                model_reset();
                cycle();
                reset = 1'b0;
            end
            for (int c = 0; c < 300; c++) begin
                for (int p = 0; p < NP; p++) begin
                    if ($urandom_range(99) < pct)
                        drive(p, code_tbl[$urandom_range(11)],
                              4'($urandom_range(rmax)), 4'($urandom_range(rmax)),
                              4'($urandom_range(rmax)));
                end
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/calc3_issue_scheduler.md
# calc3_issue_scheduler

Issue scheduler for the CALC3 datapath: accepts commands from the four requester ports (a–d), buffers them per port, and issues at most one command per cycle to the shared ALU. Arbitration is round-robin. A 16-entry register scoreboard blocks any command whose operand or result register is still being written by an in-flight command. The block sits between the port pins and the ALU issue stage, and its output bundle feeds the existing execution pipeline.

## Interface
- NPORTS, 4, number of requester ports (a..d = index 0..3)
- QDEPTH, 4, per-port queue depth; equals tag space
- ALU_LAT, 3, cycles from issue until the result register is written
- c_clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- reqcmd  in  NPORTS×4  command per port; 0 = no-op
- reqtag  in  NPORTS×2  tag per port
- req_data  in  NPORTS×32  data operand (store)
- req_d1, req_d2, req_r1  in  NPORTS×4 each  source 1, source 2 and result register
- iss_valid  out  1  issue strobe
- iss_port  out  2  granted port
- iss_cmd, iss_tag, iss_d1, iss_d2, iss_r1, iss_data  out  4/2/4/4/4/32  issued command fields
- reg_busy  out  16  scoreboard, bit n = register n pending write
- ovf_err  out  NPORTS  sticky, set when a command arrives at a full queue

## Operation
- Command classes:
  - Writers (update r1): 1 add, 2 sub, 5 shl, 6 shr, 9 store.
  - Readers of d1 and d2: 1, 2, 5, 6, 12 (branch-if-zero), 13 (branch-if-equal).
  - Reader of d1 only: 10 (fetch).
  - Other nonzero codes are queued and issued with no hazard check; the ALU returns the invalid response.
- Enqueue:
  - A nonzero reqcmd[p] is written into queue p on a c_clk edge with its tag, data, d1, d2 and r1.
  - Reqcmd 0 is ignored.
  - If queue p is full and is not dequeued in the same cycle, the command is dropped and ovf_err[p] is set. ovf_err clears only on reset.
- Eligibility: the head of queue p is eligible when the queue is non-empty and no register it reads (and, for writers, its r1) has reg_busy set. This gives RAW and WAW protection.
- Arbitration:
  - Start from the pointer rr and grant the first eligible port in order rr, rr+1, … (mod 4).
  - After a grant, rr becomes grant+1.
  - With no grant, rr holds.
  - Ineligible ports are skipped; they do not hold the slot.
- Issue:
  - The granted head is dequeued and its fields are registered onto the iss_* outputs with iss_valid=1 for one cycle.
  - On cycles with no grant, iss_valid=0 and the iss_* fields hold their last values.
- Scoreboard:
  - Issuing a writer sets reg_busy[r1].
  - A per-issue countdown (ALU_LAT-deep shift pipeline of r1 and valid) clears that bit ALU_LAT cycles after iss_valid.
  - When a clear and a set target the same register in the same cycle, the set wins.
- Order: in-order within a port (FIFO); no ordering guarantee across ports.

## Timing
- Reset values: all outputs 0, queues empty, rr=0, scoreboard pipeline empty. Reset asserted mid-operation discards all queued and in-flight state immediately.
- Enqueue-to-issue latency: the command is sampled at edge N. The earliest edge at which iss_valid=1 for it is N+1 (empty queue, no hazard, won arbitration).
- Throughput: one issue per cycle.
- Hazard release: a reader of register n issues no earlier than ALU_LAT cycles after the writer of n issued. With ALU_LAT=3 and the writer issued at edge M, reg_busy[n] is 1 for edges M..M+2 and 0 at M+3, and the reader can issue at M+3.
- Full queue with simultaneous enqueue and dequeue: accepted, count unchanged, no ovf_err.
- Queue pointers wrap modulo QDEPTH; occupancy is tracked with an extra count bit.

## Structure
- Package calc3_sched_pkg holds:
  - the cmd_e enum (NOP=0, ADD=1, SUB=2, SHL=5, SHR=6, STORE=9, FETCH=10, BZ=12, BEQ=13);
  - NPORTS;
  - the req_s struct (cmd, tag, data, d1, d2, r1);
  - the functions is_writer(), reads_d1(), reads_d2().
- Sub-module calc3_port_fifo holds one per-port queue: req_s payload, push/pop/full/empty, parameter QDEPTH. Four instances are used.

## Test plan
- Single issue: port a sends ADD d1=1 d2=2 r1=3 tag=0 at edge 0. Expect iss_valid at edge 1 with iss_port=0, iss_cmd=1, iss_r1=3, and reg_busy[3]=1 for 3 cycles.
- Round-robin: all four ports send a non-conflicting ADD in the same cycle. Expect iss_port 0,1,2,3 on four consecutive cycles. A second burst then starts from port 0 again.
- RAW hazard: port a sends ADD r1=5, then port b immediately sends SUB d1=5. Expect the SUB to issue exactly 3 cycles after the ADD, while port c's unrelated command issues in the gap.
- WAW hazard and ordering: port a sends STORE r1=7 followed by SHL r1=7. Expect the second issue ≥3 cycles after the first, in order.
- Overflow: port d sends 5 commands back-to-back while all its heads are blocked on a busy register. Expect the 5th command to be dropped, ovf_err[3]=1, and only 4 commands issued afterwards.
- Reset mid-flight: assert reset while queues hold 3 entries and reg_busy≠0. Expect all outputs 0 immediately, and no issues after release until new commands arrive.
